// File: rtl/seq_chunk_compare.sv
// Sequential chunked magnitude/equality comparator, MSB chunk first with early exit.
// Optional SEQ_CHUNK_COMPARE_SIGNED_EN adds an is_signed port for two's-complement ordering.
module seq_chunk_compare #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   mode,
`ifdef SEQ_CHUNK_COMPARE_SIGNED_EN
  input  logic         is_signed,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic         result,
  output logic         busy
);

  localparam int K  = N / W;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [N-1:0]  a_r, b_r;
  logic [2:0]    mode_r;
  logic          signed_r;
  logic [IW-1:0] idx_r, idx_s;
  logic [W-1:0]  ca_s, cb_s;
  logic          accept_s, finish_s, eq_s, gt_s, lt_s;

  // Map recorded eq/gt/lt flags onto the requested relation; reserved modes give 0.
  function automatic logic mode_result(input logic [2:0] m, input logic eq,
                                       input logic gt, input logic lt);
    logic r;
    case (m)
      3'd0:    r = eq;
      3'd1:    r = !eq;
      3'd2:    r = lt;
      3'd3:    r = lt | eq;
      3'd4:    r = gt;
      3'd5:    r = gt | eq;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Extract the current chunk of each latched operand; sign bit flipped in chunk 0 when signed.
  always_comb begin
    ca_s = W'(a_r >> (N - W - 32'(idx_r) * W));
    cb_s = W'(b_r >> (N - W - 32'(idx_r) * W));
    if (signed_r && (idx_r == {IW{1'b0}})) begin
      ca_s[W-1] = ~ca_s[W-1];
      cb_s[W-1] = ~cb_s[W-1];
    end else begin
      ca_s = ca_s;
      cb_s = cb_s;
    end
  end

  // Next-state and chunk-step decisions.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    accept_s = 1'b0;
    finish_s = 1'b0;
    eq_s     = 1'b0;
    gt_s     = (ca_s > cb_s);
    lt_s     = (ca_s < cb_s);
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept_s = 1'b1;
          idx_s    = {IW{1'b0}};
          state_s  = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (ca_s != cb_s) begin
          finish_s = 1'b1;
          state_s  = DONE;
        end else if (idx_r == LAST_IDX) begin
          finish_s = 1'b1;
          eq_s     = 1'b1;
          state_s  = DONE;
        end else begin
          idx_s = idx_r + IW'(1'b1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, latched operands, result and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= {N{1'b0}};
      b_r       <= {N{1'b0}};
      mode_r    <= 3'd0;
      signed_r  <= 1'b0;
      idx_r     <= {IW{1'b0}};
      result    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      if (accept_s) begin
        a_r    <= a;
        b_r    <= b;
        mode_r <= mode;
`ifdef SEQ_CHUNK_COMPARE_SIGNED_EN
        signed_r <= is_signed;
`else
        signed_r <= 1'b0;
`endif
      end
      if (finish_s) begin
        result <= mode_result(mode_r, eq_s, gt_s, lt_s);
      end
      in_ready  <= (state_s == IDLE);
      out_valid <= (state_s == DONE);
      busy      <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_seq_chunk_compare.sv
// Scoreboard bench for seq_chunk_compare (N=32, W=8): random and directed requests,
// expected result and latency derived from whole-operand arithmetic.
module tb_seq_chunk_compare;
  localparam int N = 32;
  localparam int W = 8;
  localparam int K = N / W;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready, result, busy;
  logic [N-1:0] a, b;
  logic [2:0]   mode;
  logic         sgn;

  seq_chunk_compare #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode),
`ifdef SEQ_CHUNK_COMPARE_SIGNED_EN
    .is_signed(sgn),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  typedef struct {
    logic res;
    int   lat;
    int   acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   bp = 2;
  bit   seen = 0;
  bit   rdy_next = 0;
  logic held;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [W-1:0] chunk(input logic [N-1:0] x, input int i);
    return W'(x / (64'd1 << (N - W * (i + 1))));
  endfunction

  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                 input logic [2:0] m, input logic s, input int acc);
    exp_t e;
    logic eq, lt, gt;
    eq = (x == y);
    lt = (x < y);
`ifdef SEQ_CHUNK_COMPARE_SIGNED_EN
    if (s) lt = ($signed(x) < $signed(y));
`else
    if (s) lt = (x < y);
`endif
    gt = !eq && !lt;
    case (m)
      3'd0: e.res = eq;
      3'd1: e.res = !eq;
      3'd2: e.res = lt;
      3'd3: e.res = lt || eq;
      3'd4: e.res = gt;
      3'd5: e.res = gt || eq;
      default: e.res = 1'b0;
    endcase
    e.lat = K;
    for (int i = K - 1; i >= 0; i--)
      if (chunk(x, i) != chunk(y, i)) e.lat = i + 1;
    e.acc = acc;
    return e;
  endfunction

  // Consumer-side ready: random, forced low, or forced high.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (bp)
        0: out_ready = ($urandom_range(0, 2) != 0);
        1: out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: check result/latency at out_valid rise, stability while held, ready after handshake.
  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
      rdy_next = 0;
    end else begin
      if (rdy_next) begin
        chk("in_ready_after_hs", in_ready, 1);
        rdy_next = 0;
      end
      if (out_valid) begin
        if (!seen) begin
          if (sb.size() == 0) begin
            chk("spurious_out_valid", out_valid, 0);
          end else begin
            cur = sb[0];
            chk("result", result, cur.res);
            chk("latency", cyc - cur.acc, cur.lat);
          end
          held = result;
          seen = 1;
        end else begin
          chk("result_stable", result, held);
        end
        chk("in_ready_in_done", in_ready, 0);
        chk("busy_in_done", busy, 1);
        if (out_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          seen = 0;
          rdy_next = 1;
        end
      end
    end
  end

  task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb2,
                       input logic [2:0] tm, input logic ts, input bit push);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", in_ready, 1);
    end else begin
      a = ta; b = tb2; mode = tm; sgn = ts; in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (push) sb.push_back(model(ta, tb2, tm, ts, cyc));
      in_valid = 1'b0;
      a = $urandom; b = $urandom; mode = 3'($urandom_range(0, 7)); sgn = $urandom_range(0, 1);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    chk("drain_timeout", 32'(sb.size()), 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    int guard;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 3'd0; sgn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Directed points
    issue(32'h12345678, 32'h12345678, 3'd0, 1'b0, 1'b1);
    issue(32'h12345678, 32'h12345678, 3'd1, 1'b0, 1'b1);
    issue(32'h80000000, 32'h7FFFFFFF, 3'd4, 1'b0, 1'b1);
    issue(32'h80000000, 32'h7FFFFFFF, 3'd4, 1'b1, 1'b1);
    issue(32'h80000000, 32'h7FFFFFFF, 3'd2, 1'b1, 1'b1);
    issue(32'h12345600, 32'h12345601, 3'd2, 1'b0, 1'b1);
    issue(32'h12345600, 32'h12345601, 3'd3, 1'b0, 1'b1);
    issue(32'h12345600, 32'h12345601, 3'd5, 1'b0, 1'b1);
    issue(32'h00000000, 32'h00000000, 3'd6, 1'b0, 1'b1);
    issue(32'h00000000, 32'h00000000, 3'd7, 1'b0, 1'b1);
    drain();

    // Backpressure with ignored in_valid pulses while DONE is held
    bp = 1;
    issue(32'h12345600, 32'h12345601, 3'd2, 1'b0, 1'b1);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_out_valid_rise", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = i[0]; a = $urandom; b = $urandom; mode = 3'($urandom_range(0, 5));
    end
    @(negedge clk);
    in_valid = 1'b0;
    bp = 2;
    drain();

    // Reset mid-BUSY aborts without emitting, then a fresh request completes
    issue(32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("busy_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    issue(32'h0, 32'h0, 3'd0, 1'b0, 1'b1);
    drain();

    // Random traffic with random backpressure
    bp = 0;
    for (int n = 0; n < 150; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = ra;
        2: rb = ra ^ (32'd1 << $urandom_range(0, N - 1));
        default: rb = ra ^ (32'd1 << $urandom_range(0, W - 1));
      endcase
      issue(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
